alu_seq: RTL
============

# alu_seq

Parametrised, clocked successor to the team's 16-bit ALU. The ALU datapath has a fixed width of N, and it implements sequential shift-add multiply and restoring divide engines. Operations are issued with a single-cycle `start`/`done` handshake, and the result and flags stay registered until the next completion. The block sits between the operand register file and the writeback stage.

## Interface
- `N`, 16, operand/result width (≥4).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue request; sampled only when idle.
- `op`  in  4  opcode, latched with operands at accept.
- `a`, `b`  in  N each  operands (signed or unsigned by op).
- `result`  out  N  primary result (low product or quotient).
- `result_hi`  out  N  high product half or remainder; 0 for single-cycle ops.
- `sign_flag`, `zero_flag`, `overflow`, `carry_flag`, `div_by_zero`  out  1 each  status flags, registered with the result.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 NOT a, 6 SHL, 7 SHR (logical), 8 SAR.
  - 9 CMP, 10 MUL (signed), 11 MULU, 12 DIV (signed), 13 DIVU.
  - 14 PASS a, 15 reserved (result 0, all flags 0).
- The state machine has two states: IDLE and BUSY.
  - IDLE to BUSY on an accepted MUL, MULU, DIV or DIVU, except when divisor b=0.
  - BUSY to IDLE on the final iteration.
  - All other accepted ops complete directly from IDLE.
- Accept rule: `start`=1 at a rising edge while in IDLE. A `start` asserted in BUSY is ignored and is not queued.
- Arithmetic:
  - ADD/SUB wrap modulo 2^N.
  - `carry_flag` is the unsigned carry-out for ADD and the borrow (a<b unsigned) for SUB/CMP; it is 0 for every other op.
  - `overflow` is the signed two's-complement overflow for ADD/SUB/CMP.
- CMP computes a−b for flags only: `result` and `result_hi` keep their previous values.
- Shifts:
  - The shift amount is all of b, read as unsigned.
  - If b ≥ N, SHL/SHR give 0 and SAR gives N copies of a[N−1].
  - `overflow` is 0 for shifts.
- MUL/MULU:
  - The 2N-bit product is split as {result_hi, result}.
  - MUL `overflow`=1 when the product does not fit in N signed bits.
  - MULU `overflow`=1 when result_hi≠0.
- DIV/DIVU:
  - The quotient goes to `result` and the remainder to `result_hi`.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - DIV of the most negative value by −1 gives `result`=most negative, `result_hi`=0, `overflow`=1.
- Division by zero (b=0, DIV or DIVU):
  - Completes as a single-cycle op.
  - Gives `result`=all ones, `result_hi`=a, `div_by_zero`=1, all other flags 0.
- Flag rules:
  - `zero_flag`=1 when `result` is 0. For MUL/MULU it means the full 2N-bit product is 0.
  - `sign_flag` is `result`[N−1]; for MUL/MULU it is `result_hi`[N−1]. For CMP it is the sign of a−b.
  - `div_by_zero` is 0 except in the division-by-zero case.
- Outputs hold their values between completions.

## Timing
- Count the accepting edge as edge 1. Latency L is the number of the edge at which results are written.
  - Single-cycle ops and division by zero: L=1.
  - MUL, MULU, DIV, DIVU: L=N+1, with one iteration on each of edges 2..N+1.
- `done` is high for exactly the one cycle following edge L.
- `busy` is high from edge 1 to edge N+1, i.e. N cycles, for multi-cycle ops only.
- Back-to-back issue: `start` high during the `done` cycle is accepted, since the block is IDLE. This gives one op per cycle for single-cycle ops.
- Changes on a, b and op after the accept edge have no effect.
- Reset (`rst`=0, at any time including mid-iteration):
  - The state goes to IDLE immediately.
  - `result`, `result_hi`, all flags, `busy` and `done` go to 0.
  - Any operation in flight is aborted; no `done` follows.
- After `rst` is released, the first edge with `start`=1 is accepted.

## Test plan
- ADD a=0x7FFF, b=0x0001 → `result`=0x8000, `overflow`=1, `sign_flag`=1, `carry_flag`=0, `done` high in the cycle after edge 1. SUB a=3, b=5 → `result`=0xFFFE, `carry_flag`=1.
- MUL a=0xFFFD (−3), b=5 → {`result_hi`,`result`}=0xFFFF_FFF1, `overflow`=0, `busy` high for 16 cycles, `done` after edge 17. MULU a=0x0100, b=0x0100 → `result_hi`=0x0001, `result`=0, `overflow`=1, `zero_flag`=0.
- DIVU 100/7 → `result`=14, `result_hi`=2. DIV −7/2 → `result`=0xFFFD, `result_hi`=0xFFFF. DIV 0x8000/0xFFFF → `result`=0x8000, `result_hi`=0, `overflow`=1.
- DIVU a=15, b=0 → `result`=0xFFFF, `result_hi`=0x000F, `div_by_zero`=1, `done` after edge 1, `busy` never high.
- SAR a=0x8000, b=20 → `result`=0xFFFF. SHL a=1, b=15 → `result`=0x8000. SHR a=0x8000, b=16 → `result`=0, `zero_flag`=1.
- Start MUL, re-pulse `start` with ADD at edge 4 (ignored), then drive `rst` low at cycle 5 → all outputs 0, no `done`. After release, CMP a=b=9 → `zero_flag`=1, `result` unchanged from 0.

Source files
------------

// File: rtl/alu_seq.sv
// Clocked N-bit ALU with sequential shift-add multiplier and restoring divider.
// Latency: 1 edge for single-cycle ops and divide-by-zero, N+1 edges for MUL/MULU/DIV/DIVU.
// Backpressure: start is accepted only in IDLE; a start seen while BUSY is dropped, not queued.
module alu_seq #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         sign_flag,
    output logic         zero_flag,
    output logic         overflow,
    output logic         carry_flag,
    output logic         div_by_zero,
    output logic         busy,
    output logic         done
);

    localparam int            CW    = $clog2(N);
    localparam logic [CW-1:0] LAST  = CW'(N - 1);
    localparam logic [N-1:0]  N_VAL = N'(N);
    localparam logic [N-1:0]  MIN_V = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
        OP_SAR, OP_CMP, OP_MUL, OP_MULU, OP_DIV, OP_DIVU, OP_PASS, OP_RSVD
    } op_e;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    op_e op_w;
    assign op_w = op_e'(op);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  work_q;     // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [N-1:0]    dvs_q;      // multiplicand or divisor magnitude
    logic            is_div_q, is_sgn_q, neg_q, neg_r_q, ovf_q;
    logic [N-1:0]    result_q, result_hi_q;
    logic            sign_q, zero_q, ovf_out_q, carry_q, dz_q, done_q;

    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign sign_flag   = sign_q;
    assign zero_flag   = zero_q;
    assign overflow    = ovf_out_q;
    assign carry_flag  = carry_q;
    assign div_by_zero = dz_q;
    assign busy        = (state_q == S_BUSY);
    assign done        = done_q;

    // Single-cycle datapath; DIV/DIVU only reach this path when b is zero.
    logic [N:0]   add_w, sub_w;
    logic [N-1:0] sc_res, sc_hi;
    logic         sc_sign, sc_zero, sc_ovf, sc_cy, sc_dz, sc_keep, big_sh;
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};

    // Decode and evaluate every single-cycle opcode.
    always_comb begin
        sc_res  = '0;
        sc_hi   = '0;
        sc_sign = 1'b0;
        sc_zero = 1'b0;
        sc_ovf  = 1'b0;
        sc_cy   = 1'b0;
        sc_dz   = 1'b0;
        sc_keep = 1'b0;
        big_sh  = (b >= N_VAL);
        case (op_w)
            OP_ADD: begin
                sc_res = add_w[N-1:0];
                sc_cy  = add_w[N];
                sc_ovf = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            OP_SUB, OP_CMP: begin
                sc_res  = sub_w[N-1:0];
                sc_cy   = sub_w[N];
                sc_ovf  = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
                sc_keep = (op_w == OP_CMP);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOT:  sc_res = ~a;
            OP_SHL:  sc_res = big_sh ? '0 : (a << b);
            OP_SHR:  sc_res = big_sh ? '0 : (a >> b);
            OP_SAR:  sc_res = big_sh ? {N{a[N-1]}} : $unsigned($signed(a) >>> b);
            OP_PASS: sc_res = a;
            OP_DIV, OP_DIVU: begin
                sc_res = '1;
                sc_hi  = a;
                sc_dz  = 1'b1;
            end
            default: ;
        endcase
        // Reserved and divide-by-zero leave sign/zero clear; CMP takes them from a-b.
        if (op_w inside {OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_NOT,
                         OP_SHL, OP_SHR, OP_SAR, OP_PASS}) begin
            sc_sign = sc_res[N-1];
            sc_zero = ~|sc_res;
        end
    end

    // Operand preparation at accept: engines work on magnitudes, sign fixed at the end.
    logic         mc_w, sgn_w, div_w, a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;
    assign div_w = (op_w == OP_DIV) || (op_w == OP_DIVU);
    assign sgn_w = (op_w == OP_MUL) || (op_w == OP_DIV);
    assign mc_w  = (op_w == OP_MUL) || (op_w == OP_MULU) || (div_w && (|b));
    assign a_neg = sgn_w & a[N-1];
    assign b_neg = sgn_w & b[N-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One shift-add or restoring-subtract iteration, then sign correction and flags.
    logic [N:0]     msum;
    logic [N+1:0]   trial;
    logic [2*N-1:0] work_d, prod_s;
    logic [N-1:0]   quo_s, rem_s, mc_res, mc_hi;
    logic           mc_sign, mc_zero, mc_ovf;
    always_comb begin
        msum  = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, dvs_q} : '0);
        trial = {1'b0, work_q[2*N-1:N], work_q[N-1]} - {2'b00, dvs_q};
        if (is_div_q) begin
            if (!trial[N+1])
                work_d = {trial[N-1:0], work_q[N-2:0], 1'b1};
            else
                work_d = {work_q[2*N-2:0], 1'b0};
        end else begin
            work_d = {msum, work_q[N-1:1]};
        end
        prod_s = neg_q   ? -work_d            : work_d;
        quo_s  = neg_q   ? -work_d[N-1:0]     : work_d[N-1:0];
        rem_s  = neg_r_q ? -work_d[2*N-1:N]   : work_d[2*N-1:N];
        if (is_div_q) begin
            mc_res  = quo_s;
            mc_hi   = rem_s;
            mc_sign = quo_s[N-1];
            mc_zero = ~|quo_s;
            mc_ovf  = ovf_q;
        end else begin
            mc_res  = prod_s[N-1:0];
            mc_hi   = prod_s[2*N-1:N];
            mc_sign = prod_s[2*N-1];
            mc_zero = ~|prod_s;
            mc_ovf  = is_sgn_q ? !((&prod_s[2*N-1:N-1]) || !(|prod_s[2*N-1:N-1]))
                               : (|prod_s[2*N-1:N]);
        end
    end

    // Control FSM with registered results, flags and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            is_div_q    <= 1'b0;
            is_sgn_q    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r_q     <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_out_q   <= 1'b0;
            carry_q     <= 1'b0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    if (mc_w) begin
                        state_q  <= S_BUSY;
                        cnt_q    <= '0;
                        work_q   <= {{N{1'b0}}, a_mag};
                        dvs_q    <= b_mag;
                        is_div_q <= div_w;
                        is_sgn_q <= sgn_w;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        ovf_q    <= sgn_w && div_w && (a == MIN_V) && (b == '1);
                    end else begin
                        done_q <= 1'b1;
                        if (!sc_keep) begin
                            result_q    <= sc_res;
                            result_hi_q <= sc_hi;
                        end
                        sign_q    <= sc_sign;
                        zero_q    <= sc_zero;
                        ovf_out_q <= sc_ovf;
                        carry_q   <= sc_cy;
                        dz_q      <= sc_dz;
                    end
                end
                S_BUSY: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q     <= S_IDLE;
                        done_q      <= 1'b1;
                        result_q    <= mc_res;
                        result_hi_q <= mc_hi;
                        sign_q      <= mc_sign;
                        zero_q      <= mc_zero;
                        ovf_out_q   <= mc_ovf;
                        carry_q     <= 1'b0;
                        dz_q        <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
